shift_window: RTL and testbench

SHIFT_WINDOW -- requirements
Module: shift_window

---
 rtl/shift_window_pkg.sv | 11 +
 rtl/shift_line.sv | 23 ++
 rtl/shift_window.sv | 102 ++++++++++
 tb/tb_shift_window.sv | 122 ++++++++++++
 4 files changed

// File: rtl/shift_window_pkg.sv
// Shared types and sizing helpers for the shift_window sliding-window block.
package shift_window_pkg;
  localparam int DATA_W_DEF = 16;

  // Counter width for a value range of n states; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [DATA_W_DEF-1:0] sample_t;
endpackage

// File: rtl/shift_line.sv
// Single LEN-deep delay line; advances only when enabled, synchronous clear.
module shift_line #(
  parameter int W   = 16,
  parameter int LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [LEN-1:0][W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_mem <= '0;
    else if (i_en)
      r_mem <= {r_mem[LEN-2:0], i_d};
  end

  assign o_q = r_mem[LEN-1];
endmodule

// File: rtl/shift_window.sv
// Multi-row sliding window: TAPS-1 chained line delays feed a registered tap bus.
// Build macro SHIFT_WINDOW_PAD_EN emits every sample, zeroing taps not yet filled.
module shift_window
  import shift_window_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAPS     = 3,
  parameter int LINE_LEN = 16,
  localparam int COL_W   = cnt_w(LINE_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   out_valid,
  output logic [TAPS*DATA_W-1:0] taps_out,
  output logic [COL_W-1:0]       col_idx
);
  localparam int FILL_MAX = (TAPS - 1) * LINE_LEN;
  localparam int FILL_W   = cnt_w(FILL_MAX + 1);

  logic                         w_acc;
  logic                         w_emit;
  logic [TAPS-2:0][DATA_W-1:0]  w_line_out;
  logic [TAPS-1:0][DATA_W-1:0]  w_taps;
  logic [TAPS-1:0][DATA_W-1:0]  r_taps;
  logic [FILL_W-1:0]            r_fill;
  logic [COL_W-1:0]             r_col;
  logic                         r_out_valid;
  logic [COL_W-1:0]             r_col_idx;

  assign w_acc = in_valid && !flush;

`ifdef SHIFT_WINDOW_PAD_EN
  assign w_emit = w_acc;
`else
  assign w_emit = w_acc && (r_fill == FILL_W'(FILL_MAX));
`endif

  for (genvar k = 0; k < TAPS - 1; k++) begin : g_line
    logic [DATA_W-1:0] w_d;
    if (k == 0) begin : g_head
      assign w_d = data_in;
    end else begin : g_chain
      assign w_d = w_line_out[k-1];
    end
    shift_line #(.W(DATA_W), .LEN(LINE_LEN)) u_line (
      .clk  (clk),
      .rst  (rst),
      .i_clr(flush),
      .i_en (w_acc),
      .i_d  (w_d),
      .o_q  (w_line_out[k])
    );
  end

  // Tap k comes from the output of line k-1, read before this edge shifts it.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [DATA_W-1:0] w_src;
    if (k == 0) begin : g_new
      assign w_src = data_in;
    end else begin : g_old
      assign w_src = w_line_out[k-1];
    end
`ifdef SHIFT_WINDOW_PAD_EN
    assign w_taps[k] = (r_fill < FILL_W'(k * LINE_LEN)) ? '0 : w_src;
`else
    assign w_taps[k] = w_src;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_fill <= '0;
      r_col  <= '0;
    end else if (w_acc) begin
      if (r_fill != FILL_W'(FILL_MAX))
        r_fill <= r_fill + 1'b1;
      r_col <= (r_col == COL_W'(LINE_LEN - 1)) ? '0 : r_col + 1'b1;
    end
  end

  // Tap bus and column only move on emitted samples so they hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_taps      <= '0;
      r_col_idx   <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_taps    <= w_taps;
        r_col_idx <= r_col;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign taps_out  = r_taps;
  assign col_idx   = r_col_idx;
endmodule

// File: tb/tb_shift_window.sv
// Randomized check of shift_window against a sample-history reference model.
module tb_shift_window;
  localparam int DW = 16;
  localparam int T  = 3;
  localparam int L  = 4;
  localparam int CW = $clog2(L);
`ifdef SHIFT_WINDOW_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, in_valid;
  logic [DW-1:0]   data_in;
  logic            out_valid;
  logic [T*DW-1:0] taps_out;
  logic [CW-1:0]   col_idx;

  int errs = 0;
  int chks = 0;

  // Reference: history of accepted samples since reset/flush, newest first.
  logic [DW-1:0]   hist[$];
  int              acc_n;
  logic            m_valid;
  logic [T*DW-1:0] m_taps;
  logic [CW-1:0]   m_col;

  shift_window #(.DATA_W(DW), .TAPS(T), .LINE_LEN(L)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .data_in(data_in), .out_valid(out_valid), .taps_out(taps_out),
    .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic f, input logic v, input logic [DW-1:0] d);
    if (r) begin
      hist.delete(); acc_n = 0; m_valid = 0; m_taps = '0; m_col = '0;
    end else if (f) begin
      hist.delete(); acc_n = 0; m_valid = 0;
    end else if (v) begin
      hist.push_front(d);
      if (hist.size() > (T-1)*L + 1) void'(hist.pop_back());
      m_valid = PAD || (acc_n >= (T-1)*L);
      if (m_valid) begin
        for (int k = 0; k < T; k++)
          m_taps[k*DW +: DW] = (k*L < hist.size()) ? hist[k*L] : '0;
        m_col = CW'(acc_n % L);
      end
      acc_n++;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [DW-1:0] d);
    rst = r; flush = f; in_valid = v; data_in = d;
    @(posedge clk);
    model(r, f, v, d);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("taps_out", 64'(taps_out), 64'(m_taps));
    if (m_valid) chk("col_idx", 64'(col_idx), 64'(m_col));
    #1;
  endtask

  initial begin
    logic [T*DW-1:0] first_win;
    rst = 1; flush = 0; in_valid = 0; data_in = '0;
    acc_n = 0; m_valid = 0; m_taps = '0; m_col = '0;
    @(negedge clk);
    step(1, 0, 0, 0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_taps", 64'(taps_out), 64'd0);

    // Back-to-back 1..12: window {1,5,9} emitted for sample 9.
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 1, DW'(i));
      if (i == 9) begin
        first_win = {16'd9, 16'd5, 16'd1};
        first_win = {first_win[15:0], first_win[31:16], first_win[47:32]};
        chk("first_win", 64'(taps_out), 64'(first_win));
        chk("first_col", 64'(col_idx), 64'd0);
        chk("first_vld", 64'(out_valid), 64'd1);
      end
    end

    // Gapped input, then flush with coincident data, then refill.
    step(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 1, DW'(i));
      step(0, 0, 0, 16'hdead);
    end
    step(0, 1, 1, 16'd99);
    for (int i = 1; i <= 10; i++) step(0, 0, 1, DW'(i));
    step(1, 0, 1, 16'd77);
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_taps", 64'(taps_out), 64'd0);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 2000; n++) begin
      logic r, f, v;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 65);
      step(r, f, v, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
